// File: rtl/dm_ctrl_pkg.sv
// Shared encodings for the data-memory controller: access types and the
// offsets of the peripheral registers inside the MMIO window.
package dm_ctrl_pkg;

  typedef enum logic [2:0] {
    dm_word              = 3'b000,
    dm_halfword          = 3'b001,
    dm_halfword_unsigned = 3'b010,
    dm_byte              = 3'b011,
    dm_byte_unsigned     = 3'b100
  } dm_type_e;

  localparam int MMIO_SPAN_BITS = 5;

  localparam logic [4:0] MMIO_LED           = 5'h00;
  localparam logic [4:0] MMIO_SW            = 5'h04;
  localparam logic [4:0] MMIO_TIMER_CNT     = 5'h08;
  localparam logic [4:0] MMIO_TIMER_CMP     = 5'h0C;
  localparam logic [4:0] MMIO_STATUS        = 5'h10;
  localparam logic [4:0] MMIO_MISALIGN_ADDR = 5'h14;

endpackage

// File: rtl/dm_timer.sv
// Free-running 32-bit timer with a compare register and a sticky match flag.
module dm_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        irq_clr,
  input  logic [31:0] wdata,
  output logic [31:0] cnt,
  output logic [31:0] cmp,
  output logic        irq
);

  logic match;

  // A compare value of zero disables the match.
  assign match = (cnt == cmp) && (cmp != 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 32'd0;
      cmp <= 32'd0;
      irq <= 1'b0;
    end else begin
      cnt <= cnt_we ? wdata : cnt + 32'd1;
      if (cmp_we) cmp <= wdata;
      if (match) irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: byte-lane RAM with sized/extended accesses plus a
// small MMIO window (LED, switches, timer, status, misaligned address).
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic        MemRead,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [2:0]  DMType,
  output logic [31:0] RData,
  input  logic [15:0] sw_in,
  output logic [15:0] led,
  output logic        timer_irq,
  output logic        misalign,
  output logic [31:0] misalign_addr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dm_type_e      dm;
  logic          in_ram;
  logic          in_mmio;
  logic [4:0]    mmio_off;
  logic [AW-1:0] word_idx;
  logic [3:0]    lane_be;
  logic [31:0]   wdata_lane;
  logic          mis;
  logic          ram_we;
  logic          mis_access;
  logic          mmio_we;
  logic [31:0]   ram_word;
  logic [31:0]   ram_shift;
  logic [31:0]   ram_load;
  logic [31:0]   mmio_rd;
  logic [15:0]   sw_meta;
  logic [15:0]   sw_sync;
  logic [31:0]   timer_cnt;
  logic [31:0]   timer_cmp;
  logic          status_we;

  logic [31:0] mem [DEPTH_WORDS];

  assign dm       = dm_type_e'(DMType);
  assign in_ram   = (Addr[31:AW+2] == '0);
  assign in_mmio  = !in_ram && (Addr[31:MMIO_SPAN_BITS] == MMIO_BASE[31:MMIO_SPAN_BITS]);
  assign mmio_off = {Addr[4:2], 2'b00};
  assign word_idx = Addr[AW+1:2];

  always_comb begin
    lane_be    = 4'b0000;
    wdata_lane = WData;
    mis        = 1'b0;
    case (dm)
      dm_word: begin
        lane_be = 4'b1111;
        mis     = (Addr[1:0] != 2'b00);
      end
      dm_halfword, dm_halfword_unsigned: begin
        lane_be    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{WData[15:0]}};
        mis        = Addr[0];
      end
      dm_byte, dm_byte_unsigned: begin
        lane_be    = 4'b0001 << Addr[1:0];
        wdata_lane = {4{WData[7:0]}};
      end
      default: lane_be = 4'b0000;
    endcase
  end

  assign ram_we     = mem_w && in_ram && !mis;
  assign mis_access = (mem_w || MemRead) && in_ram && mis;

  // RAM is intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  assign ram_word  = mem[word_idx];
  assign ram_shift = ram_word >> {Addr[1:0], 3'b000};

  always_comb begin
    ram_load = 32'd0;
    case (dm)
      dm_word:              ram_load = ram_word;
      dm_halfword:          ram_load = {{16{ram_shift[15]}}, ram_shift[15:0]};
      dm_halfword_unsigned: ram_load = {16'd0, ram_shift[15:0]};
      dm_byte:              ram_load = {{24{ram_shift[7]}}, ram_shift[7:0]};
      dm_byte_unsigned:     ram_load = {24'd0, ram_shift[7:0]};
      default:              ram_load = 32'd0;
    endcase
  end

  always_comb begin
    mmio_rd = 32'd0;
    case (mmio_off)
      MMIO_LED:           mmio_rd = {16'd0, led};
      MMIO_SW:            mmio_rd = {16'd0, sw_sync};
      MMIO_TIMER_CNT:     mmio_rd = timer_cnt;
      MMIO_TIMER_CMP:     mmio_rd = timer_cmp;
      MMIO_STATUS:        mmio_rd = {30'd0, misalign, timer_irq};
      MMIO_MISALIGN_ADDR: mmio_rd = misalign_addr;
      default:            mmio_rd = 32'd0;
    endcase
  end

  always_comb begin
    RData = 32'd0;
    if (MemRead) begin
      if (in_ram) RData = mis ? 32'd0 : ram_load;
      else if (in_mmio) RData = mmio_rd;
    end
  end

  assign mmio_we   = mem_w && in_mmio;
  assign status_we = mmio_we && (mmio_off == MMIO_STATUS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led           <= 16'd0;
      sw_meta       <= 16'd0;
      sw_sync       <= 16'd0;
      misalign      <= 1'b0;
      misalign_addr <= 32'd0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      if (mmio_we && (mmio_off == MMIO_LED)) led <= WData[15:0];
      // A new misaligned access wins over a same-cycle clear.
      if (mis_access) begin
        misalign <= 1'b1;
        if (!misalign) misalign_addr <= Addr;
      end else if (status_we && WData[1]) begin
        misalign <= 1'b0;
      end
    end
  end

  dm_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .cnt_we  (mmio_we && (mmio_off == MMIO_TIMER_CNT)),
    .cmp_we  (mmio_we && (mmio_off == MMIO_TIMER_CMP)),
    .irq_clr (status_we && WData[0]),
    .wdata   (WData),
    .cnt     (timer_cnt),
    .cmp     (timer_cmp),
    .irq     (timer_irq)
  );

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed self-checking bench for dm_ctrl: RAM sizing/extension, misalign
// handling, MMIO registers, switch synchronizer and timer.
module tb_dm_ctrl;
  import dm_ctrl_pkg::*;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic        mem_w;
  logic        MemRead;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [2:0]  DMType;
  logic [31:0] RData;
  logic [15:0] sw_in;
  logic [15:0] led;
  logic        timer_irq;
  logic        misalign;
  logic [31:0] misalign_addr;

  int checks = 0;
  int errors = 0;

  dm_ctrl #(.DEPTH_WORDS(1024), .MMIO_BASE(MB)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_w         (mem_w),
    .MemRead       (MemRead),
    .Addr          (Addr),
    .WData         (WData),
    .DMType        (DMType),
    .RData         (RData),
    .sw_in         (sw_in),
    .led           (led),
    .timer_irq     (timer_irq),
    .misalign      (misalign),
    .misalign_addr (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    Addr   = a;
    WData  = d;
    DMType = t;
    mem_w  = 1'b1;
    step();
    mem_w  = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] exp);
    Addr    = a;
    DMType  = t;
    MemRead = 1'b1;
    #1;
    check(tag, RData, exp);
    MemRead = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_w = 1'b0; MemRead = 1'b0;
    Addr = 32'd0; WData = 32'd0; DMType = 3'd0; sw_in = 16'd0;
    #1;
    check("rst_led", {16'd0, led}, 32'd0);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    check("rst_mis", {31'd0, misalign}, 32'd0);
    check("rst_mis_addr", misalign_addr, 32'd0);
    step(); step();
    reset = 1'b0;

    // Sized loads with sign/zero extension
    store(32'h10, 32'h8765_4321, dm_word);
    Addr = 32'h10; DMType = dm_word; MemRead = 1'b0; #1;
    check("rdata_no_read", RData, 32'd0);
    load_chk("lb_13",  32'h13, dm_byte,              32'hFFFF_FF87);
    load_chk("lbu_13", 32'h13, dm_byte_unsigned,     32'h0000_0087);
    load_chk("lh_12",  32'h12, dm_halfword,          32'hFFFF_8765);
    load_chk("lhu_12", 32'h12, dm_halfword_unsigned, 32'h0000_8765);
    load_chk("lb_10",  32'h10, dm_byte,              32'h0000_0021);
    load_chk("lw_10",  32'h10, dm_word,              32'h8765_4321);

    // Read-during-write shows old data; write lands at the edge
    Addr = 32'h10; DMType = dm_word; WData = 32'hCAFE_F00D; mem_w = 1'b1; MemRead = 1'b1; #1;
    check("rdw_old", RData, 32'h8765_4321);
    step();
    mem_w = 1'b0; MemRead = 1'b0;
    load_chk("rdw_new", 32'h10, dm_word, 32'hCAFE_F00D);

    // Lane-selective stores
    store(32'h20, 32'h0, dm_word);
    store(32'h21, 32'hFFFF_FFAB, dm_byte);
    load_chk("sb_21", 32'h20, dm_word, 32'h0000_AB00);
    store(32'h22, 32'h0000_1234, dm_halfword);
    load_chk("sh_22", 32'h20, dm_word, 32'h1234_AB00);

    // Out-of-range addresses neither alias into RAM nor flag misalign
    store(32'h0000_1010, 32'h5555_5555, dm_word);
    load_chk("oor_noalias", 32'h10, dm_word, 32'hCAFE_F00D);
    load_chk("oor_read", 32'h0000_1010, dm_word, 32'd0);
    check("oor_mis", {31'd0, misalign}, 32'd0);

    // Misaligned accesses
    store(32'h40, 32'h1122_3344, dm_word);
    store(32'h42, 32'hDEAD_BEEF, dm_word);
    load_chk("mis_ram_kept", 32'h40, dm_word, 32'h1122_3344);
    check("mis_set", {31'd0, misalign}, 32'd1);
    check("mis_addr", misalign_addr, 32'h42);
    Addr = 32'h45; DMType = dm_halfword; MemRead = 1'b1; #1;
    check("mis_lh_rdata", RData, 32'd0);
    step();
    MemRead = 1'b0;
    check("mis_addr_held", misalign_addr, 32'h42);
    load_chk("status_mis", MB + 32'h10, dm_word, 32'h2);
    load_chk("mmio_mis_addr", MB + 32'h14, dm_word, 32'h42);
    store(MB + 32'h10, 32'h2, dm_word);
    check("mis_clr", {31'd0, misalign}, 32'd0);

    // Switch synchronizer and LED register
    sw_in = 16'hA5A5;
    step();
    load_chk("sw_edge1", MB + 32'h04, dm_word, 32'd0);
    step();
    load_chk("sw_edge2", MB + 32'h04, dm_word, 32'h0000_A5A5);
    store(MB, 32'h0001_F00F, dm_word);
    check("led_out", {16'd0, led}, 32'h0000_F00F);
    load_chk("led_rb", MB, dm_word, 32'h0000_F00F);
    load_chk("led_rb_sized", MB + 32'h1, dm_byte, 32'h0000_F00F);
    store(MB + 32'h2, 32'h0000_1234, dm_byte);
    check("led_full_width", {16'd0, led}, 32'h0000_1234);

    // Reset clears registers without a clock edge
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_led", {16'd0, led}, 32'd0);
    check("rst_async_mis_addr", misalign_addr, 32'd0);
    reset = 1'b0;

    // Timer compare and sticky irq
    store(MB + 32'h0C, 32'd5, dm_word);
    load_chk("cnt_after_rst", MB + 32'h08, dm_word, 32'd1);
    load_chk("cmp_rb", MB + 32'h0C, dm_word, 32'd5);
    step(); step(); step(); step();
    load_chk("cnt_at_5", MB + 32'h08, dm_word, 32'd5);
    check("irq_pre", {31'd0, timer_irq}, 32'd0);
    step();
    check("irq_set", {31'd0, timer_irq}, 32'd1);
    store(MB + 32'h08, 32'd5, dm_word);
    load_chk("cnt_loaded", MB + 32'h08, dm_word, 32'd5);
    store(MB + 32'h10, 32'h1, dm_word);
    check("irq_set_wins", {31'd0, timer_irq}, 32'd1);
    store(MB + 32'h10, 32'h1, dm_word);
    check("irq_clr", {31'd0, timer_irq}, 32'd0);

    // Counter wrap and asynchronous reset mid-count
    store(MB + 32'h08, 32'hFFFF_FFFE, dm_word);
    load_chk("cnt_fffe", MB + 32'h08, dm_word, 32'hFFFF_FFFE);
    step();
    load_chk("cnt_ffff", MB + 32'h08, dm_word, 32'hFFFF_FFFF);
    step();
    load_chk("cnt_wrap", MB + 32'h08, dm_word, 32'd0);
    step();
    load_chk("cnt_one", MB + 32'h08, dm_word, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    load_chk("cnt_rst", MB + 32'h08, dm_word, 32'd0);
    load_chk("cmp_rst", MB + 32'h0C, dm_word, 32'd0);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
